wb_to_axi_txn_ctrl: RTL and testbench
=====================================

// Module: wb_to_axi_txn_ctrl
// PURPOSE
//  Sequences one Wishbone classic transaction at a time onto AXI4 single-beat transfers.
//  Drives the AR/AW address channels and the B response channel.
//  Triggers the W-mode and R-mode wb_to_axi_data_channel instances via their data_valid/data_ready handshakes.
//  Generates wb_ack/wb_err and enforces a response timeout. Sits between the WB slave port and the two data-channel instances.
// PARAMETERS
//  ADDR_WIDTH      32    width of wb_adr, axi_awaddr, axi_araddr
//  TIMEOUT_CYCLES  1024  max cycles from acceptance to completion; 0 disables timeout
//  CNT_WIDTH       11    timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  ACLK           in   1           clock, all logic on rising edge
//  ARESETN        in   1           asynchronous active-low reset
//  wb_cyc         in   1           WB cycle
//  wb_stb         in   1           WB strobe
//  wb_we          in   1           1=write, 0=read
//  wb_adr         in   ADDR_WIDTH  WB byte address
//  wb_ack         out  1           one-cycle successful completion
//  wb_err         out  1           one-cycle error completion (SLVERR/DECERR/timeout)
//  axi_awaddr     out  ADDR_WIDTH  write address
//  axi_awvalid    out  1           write address valid
//  axi_awready    in   1           write address ready
//  axi_bresp      in   2           write response
//  axi_bvalid     in   1           write response valid
//  axi_bready     out  1           write response ready
//  axi_araddr     out  ADDR_WIDTH  read address
//  axi_arvalid    out  1           read address valid
//  axi_arready    in   1           read address ready
//  axi_rresp      in   2           read response (monitored only)
//  axi_rvalid     in   1           read data valid (monitored only)
//  wr_data_valid  out  1           one-cycle start pulse to W-mode data channel
//  wr_data_ready  in   1           W beat accepted (from W-mode data channel)
//  rd_data_valid  out  1           one-cycle start pulse to R-mode data channel
//  rd_data_ready  in   1           read data captured in wb_dat_o (from R-mode data channel)
// BEHAVIOUR
//  Outputs and reset:
//   - All outputs are registered. Reset value of every output and address register is 0; state resets to IDLE.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP, DONE, ERR.
//  IDLE:
//   - On wb_cyc&wb_stb, latch wb_adr and wb_we; clear the timeout counter and flags.
//   - Read: next cycle arvalid=1 and rd_data_valid=1 (one pulse), go to RD_ADDR.
//   - Write: next cycle awvalid=1 and wr_data_valid=1 (one pulse), go to WR_XFER.
//  Address channel rules:
//   - awvalid/arvalid hold, with a stable address, until the cycle after ready is sampled high.
//   - They are never withdrawn early, including on abort or timeout.
//  RD_ADDR:
//   - On arready, drop arvalid and go to RD_DATA.
//   - rd_data_ready seen in RD_ADDR (same cycle as arready, or earlier) is remembered.
//  RD_DATA:
//   - rresp_q latches axi_rresp whenever axi_rvalid=1 in RD_ADDR/RD_DATA.
//   - When rd_data_ready is (or was) seen and arvalid is low, go to DONE.
//  WR_XFER:
//   - Flags aw_done (awvalid&awready) and w_done (wr_data_ready) set independently, in any order or the same cycle.
//   - When both are set, go to WR_RESP with bready=1.
//  WR_RESP:
//   - On bvalid&bready, latch bresp, drop bready, go to DONE.
//  DONE:
//   - Pulse wb_ack if resp==OKAY/EXOKAY, else wb_err, for exactly 1 cycle. Go to IDLE.
//   - A new request is accepted no earlier than the cycle after the ack.
//  Latency:
//   - Minimum read: ack 4 cycles after stb (zero-wait AXI).
//   - Minimum write: ack 4 cycles after stb.
//  Timeout (TIMEOUT_CYCLES>0):
//   - Counter increments in every state except IDLE/DONE/ERR.
//   - At count==TIMEOUT_CYCLES, go to ERR and pulse wb_err for 1 cycle.
//   - In ERR: deassert bready; keep any pending awvalid/arvalid until handshake; hold in ERR until address handshakes complete, then IDLE.
//   - A late R/B beat from a timed-out transaction is not reported to WB.
//   - Counter saturates; no wrap.
//  WB abort (wb_cyc low in any non-IDLE state):
//   - The AXI side completes normally.
//   - The DONE pulse is suppressed (no ack/err); return to IDLE.
//  Simultaneity:
//   - Timeout and completion in the same cycle: completion wins.
//   - Only one outstanding transaction; stb while busy is ignored.
//  Reset:
//   - Asynchronous reset mid-transaction returns to IDLE with all valids low immediately.
//   - The AXI slave must be reset with the same ARESETN.
// TESTING
//  1. Read 0x1000, arready/rvalid zero-wait, rresp=OKAY -> araddr=0x1000, one rd_data_valid pulse, wb_ack 4 cycles after stb, wb_err=0.
//  2. Write 0x2004, awready delayed 3 cycles, wr_data_ready at cycle 1, bresp=OKAY -> awvalid held 3 cycles with stable awaddr, single wb_ack after bvalid.
//  3. Write with wr_data_ready and awready in the same cycle, bresp=SLVERR(2'b10) -> WR_RESP next cycle, wb_err pulse, no wb_ack.
//  4. Read with TIMEOUT_CYCLES=16, rvalid never asserted -> wb_err exactly 16 cycles after acceptance, FSM back in IDLE, next read serviced normally.
//  5. Write, wb_cyc dropped after 2 cycles -> AW/W/B complete on the AXI side, no wb_ack/wb_err; next request accepted.
//  6. ARESETN asserted while awvalid=1 -> awvalid, bready, wb_ack, wr_data_valid all 0 immediately; state IDLE.

Source files
------------

// File: rtl/wb_to_axi_txn_ctrl.sv
// Wishbone classic -> AXI4 single-beat transaction controller.
// Accepts one WB request at a time, drives AR/AW and B, kicks the R/W
// data-channel instances with one-cycle start pulses, and reports the
// outcome as a one-cycle wb_ack / wb_err. A busy-cycle counter bounds the
// wait for the AXI side; a timed-out transaction still finishes its address
// handshake before the controller goes idle again.
module wb_to_axi_txn_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP, DONE, ERR
  } state_e;

  // Timeout fires on the busy cycle that would make the count reach TIMEOUT_CYCLES.
  localparam int                   TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] TO_LAST     = CNT_WIDTH'(TO_LAST_INT);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  awvalid_q, awvalid_d, arvalid_q, arvalid_d, bready_q, bready_d;
  logic                  wr_dv_q, wr_dv_d, rd_dv_q, rd_dv_d, ack_q, ack_d, err_q, err_d;
  logic [1:0]            resp_q, resp_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  rd_seen_q, rd_seen_d, abort_q, abort_d;

  logic accept, busy, timeout_hit, aw_hs, ar_hs, b_hs;
  logic aw_now, w_now, rd_now, abort_now, enter_err;

  // A request is not taken while the previous ack/err is still visible to the master.
  assign accept      = (state_q == IDLE) && wb_cyc && wb_stb && !ack_q && !err_q;
  assign busy        = state_q inside {RD_ADDR, RD_DATA, WR_XFER, WR_RESP};
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && busy && (cnt_q >= TO_LAST);
  assign aw_hs       = awvalid_q & axi_awready;
  assign ar_hs       = arvalid_q & axi_arready;
  assign b_hs        = bready_q & axi_bvalid;
  assign aw_now      = aw_done_q | aw_hs;
  assign w_now       = w_done_q | wr_data_ready;
  assign rd_now      = rd_seen_q | rd_data_ready;
  assign abort_now   = abort_q | ~wb_cyc;
  assign enter_err   = (state_d == ERR) && (state_q != ERR);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; progress on the AXI side takes priority over a timeout.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = wb_we ? WR_XFER : RD_ADDR;
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
               else if (timeout_hit) state_d = ERR;
      RD_DATA: if (rd_now) state_d = DONE;
               else if (timeout_hit) state_d = ERR;
      WR_XFER: if (aw_now && w_now) state_d = WR_RESP;
               else if (timeout_hit) state_d = ERR;
      WR_RESP: if (b_hs) state_d = DONE;
               else if (timeout_hit) state_d = ERR;
      DONE:    state_d = IDLE;
      ERR:     if ((!awvalid_q || axi_awready) && (!arvalid_q || axi_arready)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, flags, response and timeout counter.
  always_comb begin
    adr_d     = adr_q;
    awvalid_d = awvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rd_seen_d = rd_seen_q;
    abort_d   = abort_q;
    wr_dv_d   = 1'b0;
    rd_dv_d   = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    // Address valids are only ever released by their own handshake.
    if (aw_hs) awvalid_d = 1'b0;
    if (ar_hs) arvalid_d = 1'b0;
    if (b_hs) begin
      bready_d = 1'b0;
      resp_d   = axi_bresp;
    end
    if (busy && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    if ((state_q != IDLE) && !wb_cyc) abort_d = 1'b1;

    case (state_q)
      IDLE: if (accept) begin
        adr_d     = wb_adr;
        cnt_d     = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        rd_seen_d = 1'b0;
        abort_d   = 1'b0;
        resp_d    = 2'b00;
        if (wb_we) begin
          awvalid_d = 1'b1;
          wr_dv_d   = 1'b1;
        end else begin
          arvalid_d = 1'b1;
          rd_dv_d   = 1'b1;
        end
      end
      RD_ADDR, RD_DATA: begin
        if (axi_rvalid)    resp_d    = axi_rresp;
        if (rd_data_ready) rd_seen_d = 1'b1;
      end
      WR_XFER: begin
        if (aw_hs)            aw_done_d = 1'b1;
        if (wr_data_ready)    w_done_d  = 1'b1;
        if (aw_now && w_now)  bready_d  = 1'b1;
      end
      DONE: if (!abort_now) begin
        if (resp_q[1]) err_d = 1'b1;
        else           ack_d = 1'b1;
      end
      ERR:     bready_d = 1'b0;
      default: ;
    endcase

    // Timeout: report once (unless the master already left) and stop accepting B.
    if (enter_err) begin
      err_d    = !abort_now;
      bready_d = 1'b0;
    end
  end

  // Registered outputs and transaction context.
  // NOTE: every flop here is plain control state, so all of them take the async reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      adr_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      wr_dv_q   <= 1'b0;
      rd_dv_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      resp_q    <= 2'b00;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rd_seen_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      adr_q     <= adr_d;
      awvalid_q <= awvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      wr_dv_q   <= wr_dv_d;
      rd_dv_q   <= rd_dv_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rd_seen_q <= rd_seen_d;
      abort_q   <= abort_d;
    end
  end

  assign wb_ack        = ack_q;
  assign wb_err        = err_q;
  assign axi_awaddr    = adr_q;
  assign axi_araddr    = adr_q;
  assign axi_awvalid   = awvalid_q;
  assign axi_arvalid   = arvalid_q;
  assign axi_bready    = bready_q;
  assign wr_data_valid = wr_dv_q;
  assign rd_data_valid = rd_dv_q;

endmodule

// File: tb/tb_wb_to_axi_txn_ctrl.sv
// Bench for wb_to_axi_txn_ctrl: directed scenarios followed by randomized
// transactions. Expected completions (kind and cycle) are queued when a
// request is issued; a negedge monitor checks every ack/err and every
// address handshake against those queues.
`timescale 1ns/1ps
module tb_wb_to_axi_txn_ctrl;

  localparam int AW = 32;
  localparam int TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b1;
  logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [AW-1:0] wb_adr = '0;
  logic          wb_ack, wb_err;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic          axi_awvalid, axi_arvalid, axi_bready;
  logic          axi_awready = 1'b0, axi_arready = 1'b0;
  logic [1:0]    axi_bresp = 2'b00, axi_rresp = 2'b00;
  logic          axi_bvalid = 1'b0, axi_rvalid = 1'b0;
  logic          wr_data_valid, rd_data_valid;
  logic          wr_data_ready = 1'b0, rd_data_ready = 1'b0;

  wb_to_axi_txn_ctrl #(
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(11)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready)
  );

  always #5 ACLK = ~ACLK;

  longint cyc_cnt = 0;
  always @(posedge ACLK) cyc_cnt <= cyc_cnt + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit     is_err;
    longint due;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] aw_q[$];
  logic [AW-1:0] ar_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard monitor: every completion and address handshake must match a queued expectation.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (wb_ack || wb_err) begin
        check("completion_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("completion_kind", {wb_ack, wb_err}, e.is_err ? 2'b01 : 2'b10);
          check("completion_cycle", cyc_cnt, e.due);
        end
      end
      if (axi_awvalid && axi_awready) begin
        check("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) check("awaddr", axi_awaddr, aw_q.pop_front());
      end
      if (axi_arvalid && axi_arready) begin
        check("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) check("araddr", axi_araddr, ar_q.pop_front());
      end
    end
  end

  // AW or AR slave: ready after dly cycles of valid; address must stay stable meanwhile.
  task automatic addr_slave(input bit we, input int dly, input logic [AW-1:0] adr);
    int n = 0;
    while (!(we ? axi_awvalid : axi_arvalid) && n < 40) begin tick(); n++; end
    check("addr_valid_seen", we ? axi_awvalid : axi_arvalid, 1);
    for (int i = 0; i <= dly; i++) begin
      check("addr_stable", we ? axi_awaddr : axi_araddr, adr);
      check("addr_valid_held", we ? axi_awvalid : axi_arvalid, 1);
      if (i == dly) begin
        if (we) axi_awready = 1'b1;
        else    axi_arready = 1'b1;
      end
      tick();
      axi_awready = 1'b0;
      axi_arready = 1'b0;
    end
    check("addr_valid_dropped", we ? axi_awvalid : axi_arvalid, 0);
  endtask

  // Data-channel stand-in: waits for the start pulse, answers dly cycles later (or never).
  task automatic data_slave(input bit we, input int dly, input logic [1:0] resp, input bit never);
    int n = 0;
    while (!(we ? wr_data_valid : rd_data_valid) && n < 40) begin tick(); n++; end
    check("data_start_seen", we ? wr_data_valid : rd_data_valid, 1);
    for (int i = 0; i <= dly; i++) begin
      if (i == dly && !never) begin
        if (we) wr_data_ready = 1'b1;
        else begin
          rd_data_ready = 1'b1;
          axi_rvalid    = 1'b1;
          axi_rresp     = resp;
        end
      end
      tick();
      if (i == 0) check("data_start_one_pulse", we ? wr_data_valid : rd_data_valid, 0);
      wr_data_ready = 1'b0;
      rd_data_ready = 1'b0;
      axi_rvalid    = 1'b0;
    end
  endtask

  // B slave: once bready rises, return bresp after dly cycles.
  task automatic b_slave(input int dly, input logic [1:0] resp);
    int n = 0;
    while (!axi_bready && n < 40) begin tick(); n++; end
    check("bready_seen", axi_bready, 1);
    for (int i = 0; i <= dly; i++) begin
      check("bready_held", axi_bready, 1);
      if (i == dly) begin
        axi_bvalid = 1'b1;
        axi_bresp  = resp;
      end
      tick();
      axi_bvalid = 1'b0;
    end
    check("bready_dropped", axi_bready, 0);
  endtask

  // One WB transaction. Called one step after a rising edge (cycle 0 = stb cycle).
  // Reference timing, counted from the stb cycle:
  //   read  : ack at max(4 + ar_dly, 3 + rd_dly)
  //   write : ack at 4 + max(aw_dly, w_dly) + b_dly
  //   no read data: wb_err at TO + 1 (TO busy cycles after the accepting edge)
  task automatic run_txn(input bit we, input logic [AW-1:0] adr, input int a_dly, input int d_dly,
                         input int b_dly, input logic [1:0] resp, input int abort_at, input bit no_rdata);
    exp_t e;
    int   lat;
    if (!we && no_rdata) begin
      lat      = TO + 1;
      e.is_err = 1'b1;
    end else if (we) begin
      lat      = 4 + ((a_dly > d_dly) ? a_dly : d_dly) + b_dly;
      e.is_err = resp[1];
    end else begin
      lat      = ((4 + a_dly) > (3 + d_dly)) ? (4 + a_dly) : (3 + d_dly);
      e.is_err = resp[1];
    end
    e.due = cyc_cnt + lat;
    if (abort_at == 0) exp_q.push_back(e);
    if (we) aw_q.push_back(adr);
    else    ar_q.push_back(adr);

    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = we;
    wb_adr = adr;
    fork
      addr_slave(we, a_dly, adr);
      data_slave(we, d_dly, resp, no_rdata);
      begin
        if (we) b_slave(b_dly, resp);
      end
      begin
        if (abort_at > 0) begin
          repeat (abort_at) tick();
        end else begin
          int n = 0;
          do begin tick(); n++; end while (!(wb_ack || wb_err) && n < 60);
          check("wb_response_seen", wb_ack | wb_err, 1);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
      end
    join
    if (abort_at > 0) repeat (4) tick();
    else tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 ARESETN = 1'b0;
    #2;
    check("rst_wb_ack", wb_ack, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_valids", {axi_awvalid, axi_arvalid, axi_bready, wr_data_valid, rd_data_valid}, 0);
    check("rst_awaddr", axi_awaddr, 0);
    check("rst_araddr", axi_araddr, 0);
    @(posedge ACLK);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    tick();

    // 1: zero-wait read, OKAY
    run_txn(1'b0, 32'h0000_1000, 0, 0, 0, 2'b00, 0, 1'b0);
    // 2: write, awready late, W done early, OKAY
    run_txn(1'b1, 32'h0000_2004, 2, 0, 1, 2'b00, 0, 1'b0);
    // 3: write, AW and W together, SLVERR
    run_txn(1'b1, 32'h0000_3008, 0, 0, 0, 2'b10, 0, 1'b0);
    // 4: read timeout, then a normal read
    run_txn(1'b0, 32'h0000_4000, 0, 0, 0, 2'b00, 0, 1'b1);
    run_txn(1'b0, 32'h0000_4010, 0, 0, 0, 2'b00, 0, 1'b0);
    // 5: write aborted by the master, then a normal write
    run_txn(1'b1, 32'h0000_5000, 1, 2, 1, 2'b00, 2, 1'b0);
    run_txn(1'b1, 32'h0000_5004, 0, 1, 0, 2'b01, 0, 1'b0);
    // read with DECERR, delayed read data
    run_txn(1'b0, 32'h0000_6000, 1, 3, 0, 2'b11, 0, 1'b0);

    // 6: reset while awvalid is held
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h0000_7000;
    tick();
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check("pre_rst_awvalid", axi_awvalid, 1);
    check("pre_rst_wr_data_valid", wr_data_valid, 1);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_awvalid", axi_awvalid, 0);
    check("mid_rst_bready", axi_bready, 0);
    check("mid_rst_wb_ack", wb_ack, 0);
    check("mid_rst_wr_data_valid", wr_data_valid, 0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    tick();
    run_txn(1'b0, 32'h0000_7100, 0, 0, 0, 2'b00, 0, 1'b0);

    // Randomized transactions
    for (int k = 0; k < 30; k++) begin
      bit            we;
      logic [AW-1:0] adr;
      int            ab;
      bit            nr;
      we  = 1'($urandom_range(0, 1));
      adr = $urandom() & 32'hFFFF_FFFC;
      ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      nr  = !we && (ab == 0) && ($urandom_range(0, 7) == 0);
      run_txn(we, adr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ab, nr);
    end

    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);
    check("aw_q_drained", aw_q.size(), 0);
    check("ar_q_drained", ar_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
